// File: rtl/sum_accumulator.sv
// Sums frames of COUNT adder results into a wide total, presented on valid/ready one cycle after the last accept.
// in_ready drops while a finished result waits in DONE; nothing accepted is ever lost.
module sum_accumulator #(
  parameter int IN_WIDTH  = 33,
  parameter int ACC_WIDTH = 40,
  parameter int COUNT     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   ovf_acc;
  logic                   accept;
  logic                   last;
  logic [ACC_WIDTH:0]     sum;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign last     = (cnt == CNT_WIDTH'(COUNT - 1));
  // One extra bit catches the carry out of the accumulator for overflow tracking.
  assign sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(in_sum);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf_acc      <= 1'b0;
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_acc      <= sum[ACC_WIDTH-1:0];
              out_overflow <= ovf_acc | sum[ACC_WIDTH];
              out_valid    <= 1'b1;
              acc          <= '0;
              cnt          <= '0;
              ovf_acc      <= 1'b0;
              state        <= DONE;
            end else begin
              acc     <= sum[ACC_WIDTH-1:0];
              ovf_acc <= ovf_acc | sum[ACC_WIDTH];
              cnt     <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of the 33-bit registered adder output (`out_sum` of the two-stage adder).
- Accumulates a frame of COUNT consecutive sums into a wider accumulator, then presents the frame total on a valid/ready output.
- Sits between the adder pipeline and the result sink.
- Applies backpressure to the upstream stage while a finished result is waiting to be taken.

Parameters:
- IN_WIDTH, 33, width of incoming sum (adder carry plus 32-bit sum).
- ACC_WIDTH, 40, accumulator/result width; must be >= IN_WIDTH.
- COUNT, 4, sums per frame; legal range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 8, width of the frame counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block accepts in_sum this cycle.
- in_sum  input  IN_WIDTH  unsigned sum from the adder stage.
- out_valid  output  1  out_acc/out_overflow hold a completed frame result.
- out_ready  input  1  sink takes the result this cycle.
- out_acc  output  ACC_WIDTH  frame total, modulo 2^ACC_WIDTH.
- out_overflow  output  1  frame total exceeded 2^ACC_WIDTH-1.

Behaviour:
- Reset: one clock edge with reset==0 sets:
  - state=ACCUM, acc=0, cnt=0, ovf_acc=0;
  - out_valid=0, out_acc=0, out_overflow=0.
  - Reset dominates every other input in the same cycle.
- in_ready is combinational: 1 iff state==ACCUM. It never depends on in_valid.
- Accept = in_valid & in_ready. All arithmetic is unsigned; in_sum is zero-extended to ACC_WIDTH+1 bits.
- ACCUM on accept, not the last sample (cnt < COUNT-1):
  - acc <= acc + in_sum (low ACC_WIDTH bits);
  - ovf_acc <= ovf_acc | carry out of bit ACC_WIDTH-1;
  - cnt <= cnt + 1.
- ACCUM on accept, last sample (cnt == COUNT-1):
  - out_acc <= acc + in_sum (low ACC_WIDTH bits);
  - out_overflow <= ovf_acc | that add's carry;
  - out_valid <= 1; acc <= 0; cnt <= 0; ovf_acc <= 0; state <= DONE.
- ACCUM with no accept: all state is held. Gaps in in_valid are legal and do not break a frame.
- Latency: out_valid rises on the clock edge that accepts the last sample, so it is visible the cycle after that accept.
- DONE:
  - in_ready=0.
  - out_valid, out_acc and out_overflow are held stable until out_valid & out_ready.
  - On that handshake: out_valid <= 0 and state <= ACCUM. in_ready is 1 the following cycle.
  - out_acc/out_overflow keep their last value after the handshake until the next frame completes.
- out_ready is ignored while out_valid==0.
- COUNT==1: every accepted sum goes straight to DONE. Peak throughput is one result per 2 cycles.
- Throughput: one frame per COUNT+1 cycles at best (COUNT accepts plus one DONE cycle with out_ready=1).
- Wrap-around: the accumulator wraps modulo 2^ACC_WIDTH. out_overflow is per frame and never sticky across frames.
- Reset mid-frame: the partial accumulation is discarded and the next accepted sample starts a new frame.
- Reset while in DONE: the pending result is dropped (out_valid=0).
- The upstream adder stage has no stall. The integrating level must gate its in_valid or hold its inputs when in_ready==0. This block never drops an accepted sample.

Test Plan:
- Basic frame (defaults): reset low 2 cycles; accept sums 1, 2, 3, 4 back-to-back -> out_valid=1 the cycle after the 4th accept, out_acc=10, out_overflow=0, in_ready=0 while out_valid=1.
- Max input, no overflow: 4 sums of 0x1_FFFF_FFFF -> out_acc=0x07_FFFF_FFFC, out_overflow=0.
- Overflow (ACC_WIDTH=34): 4 sums of 0x1_FFFF_FFFF -> out_acc=0x3_FFFF_FFFC, out_overflow=1. A next frame of 1, 1, 1, 1 -> out_acc=4, out_overflow=0.
- Backpressure and gaps: in_valid toggling 1,0,1,0,... for values 5, 6, 7, 8; out_ready held 0 for 6 cycles after out_valid -> out_acc=26 stable, in_ready=0 throughout. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Reset mid-frame: accept 100, 200; drive reset=0 for 1 cycle; then accept 1, 2, 3, 4 -> out_acc=10 (not 310). A reset asserted during DONE -> out_valid=0 the next cycle.
- COUNT=1: sums 7 then 9 with out_ready=1 -> two results, 7 then 9, each one cycle after its accept; in_ready pattern is 1,0,1,0.
